// File: rtl/spi_link_pkg.sv
// Shared types and constants for the SPI ALU link master.
//   state_e      : transaction FSM states
//   FRAME_BITS   : bits per CS-low frame (3 bytes)
//   RESP_*       : where the slave's reply sits in the frame and in the reply byte
//   build_frame  : packs the outgoing {A,B}, {6'b0,op}, dummy bytes MSB first
package spi_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int unsigned FRAME_BITS    = 24;
    localparam int unsigned RESP_BYTE_IDX = 2;

    // Bit positions inside the reply byte
    localparam int unsigned RESP_Z_POS   = 7;
    localparam int unsigned RESP_C_POS   = 6;
    localparam int unsigned RESP_V_POS   = 5;
    localparam int unsigned RESP_N_POS   = 4;
    localparam int unsigned RESP_RES_MSB = 3;
    localparam int unsigned RESP_RES_LSB = 0;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [1:0] op
    );
        return {a, b, 6'b0, op, 8'h00};
    endfunction

endpackage

// File: rtl/spi_master_alu_link_if.sv
// Bundle of the front-end handshake and SPI pin signals of the ALU link master.
//   front end : start, a, b, op (in to master); result, z/c/v/n, busy, done (out)
//   SPI pins  : cs, sclk, mosi (out of master); miso (in to master)
// modport master is used by spi_master_alu_link; modport slave is the far side
// (front end plus SPI slave board).
interface spi_master_alu_link_if;

    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       miso;
    logic       cs;
    logic       sclk;
    logic       mosi;
    logic [3:0] result;
    logic       z;
    logic       c;
    logic       v;
    logic       n;
    logic       busy;
    logic       done;

    modport master (
        input  start, a, b, op, miso,
        output cs, sclk, mosi, result, z, c, v, n, busy, done
    );

    modport slave (
        output start, a, b, op, miso,
        input  cs, sclk, mosi, result, z, c, v, n, busy, done
    );

endinterface

// File: rtl/spi_tick_gen.sv
// Half-period tick generator for the SPI clock.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_enable       : counting enabled; counter held at 0 while low
//   o_tick         : one-cycle pulse every CLK_DIV cycles while enabled
module spi_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    output logic o_tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("spi_tick_gen: CLK_DIV must be 1 or greater");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);
    assign o_tick = i_enable && w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_enable || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_alu_link.sv
// SPI mode-0 master that runs one ALU transaction per accepted start:
// sends {A,B}, {6'b0,op}, dummy; keeps the MISO byte received during the dummy
// byte as {Z,C,V,N,result}.
//   i_clk, i_rst_n : system clock, async active-low reset
//   spi_bus        : front-end handshake and SPI pins (master modport)
// CS, SCLK and MOSI are driven directly from flops.
module spi_master_alu_link
    import spi_link_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    spi_master_alu_link_if.master spi_bus
);

    state_e                r_state;
    logic [4:0]            r_bit_cnt;   // falling SCLK edges seen in this frame
    logic [FRAME_BITS-1:0] r_tx;        // MSB is the bit currently on MOSI
    logic [7:0]            r_rx;
    logic                  r_cs;
    logic                  r_sclk;
    logic [3:0]            r_result;
    logic                  r_z;
    logic                  r_c;
    logic                  r_v;
    logic                  r_n;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_tick;
    logic                  w_tick_en;
    logic                  w_last_bit;
    logic                  w_in_resp;

    assign w_tick_en  = (r_state != IDLE);
    assign w_last_bit = (r_bit_cnt == 5'(FRAME_BITS - 1));
    assign w_in_resp  = (r_bit_cnt >= 5'(RESP_BYTE_IDX * 8));

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (w_tick_en),
        .o_tick   (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_cs      <= 1'b1;
            r_sclk    <= 1'b0;
            r_result  <= '0;
            r_z       <= 1'b0;
            r_c       <= 1'b0;
            r_v       <= 1'b0;
            r_n       <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (spi_bus.start) begin
                        r_state   <= SETUP;
                        r_cs      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_tx      <= build_frame(spi_bus.a, spi_bus.b, spi_bus.op);
                        r_rx      <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_sclk  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (r_sclk) begin
                            // End of high phase: sample MISO, advance MOSI
                            r_sclk    <= 1'b0;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (w_in_resp) begin
                                r_rx <= {r_rx[6:0], spi_bus.miso};
                            end
                            // Last bit stays on MOSI through HOLD
                            if (!w_last_bit) begin
                                r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
                            end
                        end else if (r_bit_cnt == 5'(FRAME_BITS)) begin
                            r_state <= HOLD;
                        end else begin
                            r_sclk <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_cs      <= 1'b1;
                        r_result  <= r_rx[RESP_RES_MSB:RESP_RES_LSB];
                        r_z       <= r_rx[RESP_Z_POS];
                        r_c       <= r_rx[RESP_C_POS];
                        r_v       <= r_rx[RESP_V_POS];
                        r_n       <= r_rx[RESP_N_POS];
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign spi_bus.cs     = r_cs;
    assign spi_bus.sclk   = r_sclk;
    assign spi_bus.mosi   = r_tx[FRAME_BITS-1];
    assign spi_bus.result = r_result;
    assign spi_bus.z      = r_z;
    assign spi_bus.c      = r_c;
    assign spi_bus.v      = r_v;
    assign spi_bus.n      = r_n;
    assign spi_bus.busy   = r_busy;
    assign spi_bus.done   = r_done;

endmodule

// File: tb/tb_spi_master_alu_link.sv
// Bench for spi_master_alu_link: one instance with CLK_DIV=4 (index 0) and one
// with CLK_DIV=1 (index 1), each with a behavioural SPI slave that returns
// {garbage16, reply byte} MSB first and records the MOSI stream.
module tb_spi_master_alu_link;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_master_alu_link_if if4 ();
    spi_master_alu_link_if if1 ();

    spi_master_alu_link #(.CLK_DIV(4)) u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .spi_bus (if4.master)
    );

    spi_master_alu_link #(.CLK_DIV(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .spi_bus (if1.master)
    );

    // Stimulus and observation, indexed by instance
    logic [1:0] t_start = '0;
    logic [3:0] t_a [2];
    logic [3:0] t_b [2];
    logic [1:0] t_op [2];
    logic [1:0] t_miso = '0;
    logic [1:0] w_cs, w_sclk, w_mosi, w_busy, w_done;
    logic [3:0] w_result [2];
    logic [3:0] w_flags [2];

    assign if4.start = t_start[0];
    assign if4.a     = t_a[0];
    assign if4.b     = t_b[0];
    assign if4.op    = t_op[0];
    assign if4.miso  = t_miso[0];
    assign if1.start = t_start[1];
    assign if1.a     = t_a[1];
    assign if1.b     = t_b[1];
    assign if1.op    = t_op[1];
    assign if1.miso  = t_miso[1];

    assign w_cs        = {if1.cs, if4.cs};
    assign w_sclk      = {if1.sclk, if4.sclk};
    assign w_mosi      = {if1.mosi, if4.mosi};
    assign w_busy      = {if1.busy, if4.busy};
    assign w_done      = {if1.done, if4.done};
    assign w_result[0] = if4.result;
    assign w_result[1] = if1.result;
    assign w_flags[0]  = {if4.z, if4.c, if4.v, if4.n};
    assign w_flags[1]  = {if1.z, if1.c, if1.v, if1.n};

    // Cycle counter and slave model
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  p_cs   = 2'b11;
    logic [1:0]  p_sclk = 2'b00;
    int          s_idx [2]  = '{0, 0};
    logic [23:0] s_word [2] = '{24'h0, 24'h0};
    logic [23:0] s_mosi [2] = '{24'h0, 24'h0};
    int          s_rise [2] = '{0, 0};

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (p_cs[g] && !w_cs[g]) begin
                s_idx[g]  <= 23;
                t_miso[g] <= s_word[g][23];
            end else if (p_sclk[g] && !w_sclk[g] && !w_cs[g] && s_idx[g] > 0) begin
                s_idx[g]  <= s_idx[g] - 1;
                t_miso[g] <= s_word[g][s_idx[g] - 1];
            end
            if (!p_sclk[g] && w_sclk[g]) begin
                s_mosi[g] <= {s_mosi[g][22:0], w_mosi[g]};
                s_rise[g] <= s_rise[g] + 1;
            end
            p_cs[g]   <= w_cs[g];
            p_sclk[g] <= w_sclk[g];
        end
    end

    // Reference model
    function automatic logic [23:0] ref_frame(input logic [3:0] a, input logic [3:0] b,
                                              input logic [1:0] op);
        int unsigned v;
        v = (int'(a) * 16 + int'(b)) * 65536 + int'(op) * 256;
        return v[23:0];
    endfunction

    function automatic logic [3:0] ref_result(input logic [7:0] resp);
        int unsigned v;
        v = int'(resp) % 16;
        return v[3:0];
    endfunction

    function automatic logic [3:0] ref_flags(input logic [7:0] resp);
        int unsigned v;
        v = int'(resp) / 16;
        return v[3:0];
    endfunction

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_idle(input int sel);
        chk("idle_cs", w_cs[sel], 1);
        chk("idle_sclk", w_sclk[sel], 0);
        chk("idle_mosi", w_mosi[sel], 0);
        chk("idle_busy", w_busy[sel], 0);
        chk("idle_done", w_done[sel], 0);
        chk("idle_result", w_result[sel], 0);
        chk("idle_flags", w_flags[sel], 0);
    endtask

    task automatic run_txn(input int sel, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op, input logic [7:0] resp,
                           input logic [15:0] garb, input logic [23:0] exp_frame,
                           input logic [3:0] exp_res, input logic [3:0] exp_flags,
                           input bit repulse, input bit hold);
        int d;
        int rise0;
        int unsigned k;
        bit seen;
        int lows;
        d = (sel == 0) ? 4 : 1;
        @(negedge clk);
        s_word[sel]  = {garb, resp};
        t_a[sel]     = a;
        t_b[sel]     = b;
        t_op[sel]    = op;
        t_start[sel] = 1'b1;
        rise0        = s_rise[sel];
        @(posedge clk);
        #1;
        k = cyc;
        chk("start_cs_low", w_cs[sel], 0);
        chk("start_busy", w_busy[sel], 1);
        chk("start_mosi_msb", w_mosi[sel], a[3]);
        @(negedge clk);
        if (!hold) t_start[sel] = 1'b0;
        // Only the latched operands may reach MOSI
        t_a[sel]  = 4'($urandom);
        t_b[sel]  = 4'($urandom);
        t_op[sel] = 2'($urandom);
        seen = 1'b0;
        for (int n = 0; n < 60 * d + 20; n++) begin
            @(negedge clk);
            if (repulse && n == 21 * d) t_start[sel] = 1'b1;
            if (repulse && n == 21 * d + 1) t_start[sel] = 1'b0;
            if (w_done[sel]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("done_latency", cyc - k, 50 * d);
            chk("busy_at_done", w_busy[sel], 0);
            chk("cs_at_done", w_cs[sel], 1);
            chk("result", w_result[sel], exp_res);
            chk("flags_zcvn", w_flags[sel], exp_flags);
            chk("sclk_rises", s_rise[sel] - rise0, 24);
            chk("mosi_frame", s_mosi[sel], exp_frame);
            @(negedge clk);
            if (hold) begin
                chk("hold_restart_cs", w_cs[sel], 0);
                chk("hold_restart_busy", w_busy[sel], 1);
                t_start[sel] = 1'b0;
                seen = 1'b0;
                for (int m = 0; m < 60 * d + 20; m++) begin
                    @(negedge clk);
                    if (w_done[sel]) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("hold_second_done", seen, 1);
                chk("hold_second_result", w_result[sel], exp_res);
            end else begin
                chk("done_one_cycle", w_done[sel], 0);
                if (repulse) begin
                    lows = 0;
                    for (int m = 0; m < 4 * d + 4; m++) begin
                        @(negedge clk);
                        if (!w_cs[sel]) lows++;
                    end
                    chk("no_queued_start", lows, 0);
                end
            end
        end
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  b;
        logic [1:0]  op;
        logic [7:0]  resp;
        logic [23:0] exp_frame;
        logic [3:0]  exp_res;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs [5];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        int rise0;
        int dones;
        bit hit;
        logic [3:0]  ra, rb;
        logic [1:0]  rop;
        logic [7:0]  rr;

        vecs[0] = '{4'h3, 4'h5, 2'b00, 8'h08, 24'h350000, 4'h8, 4'h0};
        vecs[1] = '{4'h3, 4'h5, 2'b10, 8'hA7, 24'h350200, 4'h7, 4'hA};
        vecs[2] = '{4'hF, 4'hF, 2'b11, 8'hFF, 24'hFF0300, 4'hF, 4'hF};
        vecs[3] = '{4'h0, 4'h0, 2'b01, 8'h00, 24'h000100, 4'h0, 4'h0};
        vecs[4] = '{4'hA, 4'h6, 2'b10, 8'h5C, 24'hA60200, 4'hC, 4'h5};

        for (int i = 0; i < 2; i++) begin
            t_a[i]  = '0;
            t_b[i]  = '0;
            t_op[i] = '0;
        end

        #12;
        chk_idle(0);
        chk_idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_txn(0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].resp, 16'($urandom),
                    vecs[i].exp_frame, vecs[i].exp_res, vecs[i].exp_flags, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            run_txn(1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].resp, 16'($urandom),
                    vecs[i].exp_frame, vecs[i].exp_res, vecs[i].exp_flags, 1'b0, 1'b0);
        end

        // Reset while idle with non-zero result held
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_idle(0);
        chk_idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Second start pulse mid-frame, then start held high
        run_txn(0, vecs[1].a, vecs[1].b, vecs[1].op, vecs[1].resp, 16'hBEEF,
                vecs[1].exp_frame, vecs[1].exp_res, vecs[1].exp_flags, 1'b1, 1'b0);
        run_txn(0, vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].resp, 16'h1234,
                vecs[0].exp_frame, vecs[0].exp_res, vecs[0].exp_flags, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Reset during the 11th SCLK high phase
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        s_word[0]  = {16'hFFFF, 8'h3C};
        t_a[0]     = 4'h9;
        t_b[0]     = 4'h1;
        t_op[0]    = 2'b01;
        t_start[0] = 1'b1;
        rise0      = s_rise[0];
        @(negedge clk);
        t_start[0] = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_rise[0] - rise0 >= 11) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_11th_rise", hit, 1);
        @(negedge clk);
        chk("sclk_high_before_rst", w_sclk[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_cs", w_cs[0], 1);
        chk("rst_mid_sclk", w_sclk[0], 0);
        chk("rst_mid_busy", w_busy[0], 0);
        chk("rst_mid_done", w_done[0], 0);
        chk("rst_mid_result", w_result[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 220; n++) begin
            @(negedge clk);
            if (w_done[0]) dones++;
        end
        chk("aborted_no_done", dones, 0);
        chk("aborted_result", w_result[0], 0);
        chk("aborted_flags", w_flags[0], 0);
        run_txn(0, vecs[4].a, vecs[4].b, vecs[4].op, vecs[4].resp, 16'h0F0F,
                vecs[4].exp_frame, vecs[4].exp_res, vecs[4].exp_flags, 1'b0, 1'b0);

        // Randomized transactions against the reference model
        for (int i = 0; i < 10; i++) begin
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            rop = 2'($urandom);
            rr  = 8'($urandom);
            run_txn((i < 6) ? 0 : 1, ra, rb, rop, rr, 16'($urandom),
                    ref_frame(ra, rb, rop), ref_result(rr), ref_flags(rr), 1'b0, 1'b0);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
